sram_rr_arbiter: RTL and testbench

//  Shares one SRAM_Controller (32-bit word port over the 16-bit SRAM) between two requesters,
//  e.g. instruction fetch (rq0) and MEM stage (rq1). Round-robin grant, one transaction in

---
 rtl/sram_rr_arbiter_if.sv | 57 +++++
 rtl/sram_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_arbiter_if.sv
// Bundle of requester and SRAM-controller signals for sram_rr_arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface sram_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rq0_write_en;
  logic              rq0_read_en;
  logic [ADDR_W-1:0] rq0_address;
  logic [DATA_W-1:0] rq0_write_data;
  logic [DATA_W-1:0] rq0_read_data;
  logic              rq0_done;
  logic              rq0_stall;

  logic              rq1_write_en;
  logic              rq1_read_en;
  logic [ADDR_W-1:0] rq1_address;
  logic [DATA_W-1:0] rq1_write_data;
  logic [DATA_W-1:0] rq1_read_data;
  logic              rq1_done;
  logic              rq1_stall;

  logic              mem_write_en;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_ready;

  logic              arb_error;

  modport slave (
    input  rq0_write_en, rq0_read_en,
    input  rq0_address, rq0_write_data,
    output rq0_read_data, rq0_done, rq0_stall,
    input  rq1_write_en, rq1_read_en,
    input  rq1_address, rq1_write_data,
    output rq1_read_data, rq1_done, rq1_stall,
    output mem_write_en, mem_read_en,
    output mem_address, mem_write_data,
    input  mem_read_data, mem_ready,
    output arb_error
  );

  modport master (
    output rq0_write_en, rq0_read_en,
    output rq0_address, rq0_write_data,
    input  rq0_read_data, rq0_done, rq0_stall,
    output rq1_write_en, rq1_read_en,
    output rq1_address, rq1_write_data,
    input  rq1_read_data, rq1_done, rq1_stall,
    input  mem_write_en, mem_read_en,
    input  mem_address, mem_write_data,
    output mem_read_data, mem_ready,
    input  arb_error
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of the 32-bit SRAM controller.
// Optional BUSY watchdog is enabled with SRAM_ARB_TIMEOUT_EN.
module sram_rr_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  sram_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;
  logic              done0_q;
  logic              done1_q;

  logic              valid0;
  logic              valid1;
  logic              grant_d;
  logic              sel_we;
  logic              sel_re;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam logic [6:0] TO_LAST = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] cnt_q;
  logic       err_q;
`endif

  // Pick the next owner; a write wins over a read from the same requester.
  always_comb begin
    valid0 = bus.rq0_write_en | bus.rq0_read_en;
    valid1 = bus.rq1_write_en | bus.rq1_read_en;
    if (valid0 && valid1) begin
      grant_d = ~last_grant_q;
    end else if (valid1) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
    sel_we    = grant_d ? bus.rq1_write_en
                        : bus.rq0_write_en;
    sel_re    = grant_d ?
                (bus.rq1_read_en & ~bus.rq1_write_en) :
                (bus.rq0_read_en & ~bus.rq0_write_en);
    sel_addr  = grant_d ? bus.rq1_address
                        : bus.rq0_address;
    sel_wdata = grant_d ? bus.rq1_write_data
                        : bus.rq0_write_data;
  end

  // Transaction FSM with all controller-facing outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid0 || valid1) begin
            mem_we_q     <= sel_we;
            mem_re_q     <= sel_re;
            mem_addr_q   <= sel_addr;
            mem_wdata_q  <= sel_wdata;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SRAM_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= BUSY;
        end
        BUSY: begin
          if (bus.mem_ready) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            if (grant_q) begin
              done1_q <= 1'b1;
              if (mem_re_q) rd1_q <= bus.mem_read_data;
            end else begin
              done0_q <= 1'b1;
              if (mem_re_q) rd0_q <= bus.mem_read_data;
            end
            state_q <= DONE;
`ifdef SRAM_ARB_TIMEOUT_EN
          end else if (cnt_q == TO_LAST) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            err_q    <= 1'b1;
            if (grant_q) begin
              done1_q <= 1'b1;
              if (mem_re_q) rd1_q <= DATA_W'(32'hDEAD_BEEF);
            end else begin
              done0_q <= 1'b1;
              if (mem_re_q) rd0_q <= DATA_W'(32'hDEAD_BEEF);
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 7'd1;
`endif
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_write_en   = mem_we_q;
  assign bus.mem_read_en    = mem_re_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.rq0_read_data  = rd0_q;
  assign bus.rq1_read_data  = rd1_q;
  assign bus.rq0_done       = done0_q;
  assign bus.rq1_done       = done1_q;
  assign bus.rq0_stall      = valid0 & ~done0_q;
  assign bus.rq1_stall      = valid1 & ~done1_q;

`ifdef SRAM_ARB_TIMEOUT_EN
  assign bus.arb_error = err_q;
`else
  // Without the watchdog the limit has no effect and the flag stays low.
  assign bus.arb_error = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural SRAM controller.
// The controller drops ready for 6 cycles per accepted op (or forever when hung).
module tb_sram_rr_arbiter;

  logic clk;
  logic rst;
  logic hang;
  int   errs;
  int   checks;

  sram_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_rr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:255];
  logic        lat_re;
  logic [7:0]  lat_idx;
  int          m_cnt;
  logic        m_ack;

  // Behavioural controller: accept, hold ready low 6 cycles, then ready.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_ready     <= 1'b1;
      bus.mem_read_data <= '0;
      m_cnt             <= 0;
      m_ack             <= 1'b0;
      lat_re            <= 1'b0;
      lat_idx           <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        bus.mem_ready <= 1'b1;
        m_ack         <= 1'b1;
        if (lat_re) bus.mem_read_data <= mem_arr[lat_idx];
      end
    end else if (m_ack) begin
      if (!bus.mem_write_en && !bus.mem_read_en) m_ack <= 1'b0;
    end else if (bus.mem_write_en || bus.mem_read_en) begin
      bus.mem_ready <= 1'b0;
      if (!hang) m_cnt <= 6;
      if (bus.mem_write_en)
        mem_arr[bus.mem_address[9:2]] <= bus.mem_write_data;
      lat_re  <= bus.mem_read_en;
      lat_idx <= bus.mem_address[9:2];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          n;
  logic        s1;
  logic        dseen;
  logic [1:0]  who;

  initial begin
    errs   = 0;
    checks = 0;
    hang   = 1'b0;
    rst    = 1'b0;
    bus.rq0_write_en   = 1'b0;
    bus.rq0_read_en    = 1'b0;
    bus.rq0_address    = '0;
    bus.rq0_write_data = '0;
    bus.rq1_write_en   = 1'b0;
    bus.rq1_read_en    = 1'b0;
    bus.rq1_address    = '0;
    bus.rq1_write_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_we", bus.mem_write_en, 1'b0);
    chk("rst_mem_re", bus.mem_read_en, 1'b0);
    chk("rst_mem_addr", bus.mem_address, 32'h0);
    chk("rst_done0", bus.rq0_done, 1'b0);
    chk("rst_done1", bus.rq1_done, 1'b0);
    chk("rst_rd0", bus.rq0_read_data, 32'h0);
    chk("rst_rd1", bus.rq1_read_data, 32'h0);
    chk("rst_err", bus.arb_error, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // 1: rq0 write 1029
    bus.rq0_write_en   = 1'b1;
    bus.rq0_address    = 32'd1029;
    bus.rq0_write_data = 32'h0002_0001;
    #1 chk("t1_stall0_req", bus.rq0_stall, 1'b1);
    @(negedge clk);
    chk("t1_mem_we", bus.mem_write_en, 1'b1);
    chk("t1_mem_re", bus.mem_read_en, 1'b0);
    chk("t1_addr", bus.mem_address, 32'd1029);
    chk("t1_wdata", bus.mem_write_data, 32'h0002_0001);
    n  = 0;
    s1 = 1'b0;
    do begin
      @(negedge clk);
      n++;
      s1 = s1 | bus.rq1_stall;
    end while (!bus.rq0_done && n < 100);
    chk("t1_latency", n, 8);
    chk("t1_we_off", bus.mem_write_en, 1'b0);
    chk("t1_stall0_done", bus.rq0_stall, 1'b0);
    chk("t1_stall1", s1, 1'b0);
    bus.rq0_write_en = 1'b0;
    @(negedge clk);
    chk("t1_pulse", bus.rq0_done, 1'b0);

    // 2: rq0 read 1029
    bus.rq0_read_en = 1'b1;
    @(negedge clk);
    chk("t2_mem_re", bus.mem_read_en, 1'b1);
    chk("t2_mem_we", bus.mem_write_en, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rq0_done && n < 100);
    chk("t2_latency", n, 8);
    chk("t2_rdata", bus.rq0_read_data, 32'h0002_0001);
    bus.rq0_read_en = 1'b0;
    @(negedge clk);

    // 4: rq1 write and read together -> write only
    bus.rq1_write_en   = 1'b1;
    bus.rq1_read_en    = 1'b1;
    bus.rq1_address    = 32'd8;
    bus.rq1_write_data = 32'hA5A5_0001;
    @(negedge clk);
    chk("t4_mem_we", bus.mem_write_en, 1'b1);
    chk("t4_mem_re", bus.mem_read_en, 1'b0);
    chk("t4_addr", bus.mem_address, 32'd8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rq1_done && n < 100);
    chk("t4_latency", n, 8);
    chk("t4_rd1_kept", bus.rq1_read_data, 32'h0);
    chk("t4_done0", bus.rq0_done, 1'b0);
    bus.rq1_write_en = 1'b0;
    bus.rq1_read_en  = 1'b0;
    @(negedge clk);
    chk("t4_pulse", bus.rq1_done, 1'b0);

    // 5: reset in BUSY
    bus.rq0_read_en = 1'b1;
    bus.rq0_address = 32'd8;
    @(negedge clk);
    chk("t5_mem_re", bus.mem_read_en, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("t5_async_re", bus.mem_read_en, 1'b0);
    chk("t5_rd0_rst", bus.rq0_read_data, 32'h0);
    bus.rq0_read_en = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    dseen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      dseen = dseen | bus.rq0_done | bus.rq1_done;
    end
    chk("t5_no_done", dseen, 1'b0);
    bus.rq0_read_en = 1'b1;
    @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rq0_done && n < 100);
    chk("t5_next_lat", n, 8);
    chk("t5_next_rd", bus.rq0_read_data, 32'hA5A5_0001);
    bus.rq0_read_en = 1'b0;
    @(negedge clk);

    // 3: both read after reset, held -> 0,1,0,1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.rq0_read_en = 1'b1;
    bus.rq0_address = 32'd1029;
    bus.rq1_read_en = 1'b1;
    bus.rq1_address = 32'd8;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.rq0_done || bus.rq1_done) && n < 100);
      who = {bus.rq1_done, bus.rq0_done};
      chk($sformatf("t3_order%0d", i), who,
          (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t3_gap%0d", i), n, (i == 0) ? 9 : 10);
      if (i % 2 == 0) begin
        chk($sformatf("t3_rd0_%0d", i),
            bus.rq0_read_data, 32'h0002_0001);
        chk($sformatf("t3_stall1_%0d", i), bus.rq1_stall, 1'b1);
      end else begin
        chk($sformatf("t3_rd1_%0d", i),
            bus.rq1_read_data, 32'hA5A5_0001);
        chk($sformatf("t3_stall0_%0d", i), bus.rq0_stall, 1'b1);
      end
    end
    bus.rq0_read_en = 1'b0;
    bus.rq1_read_en = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SRAM_ARB_TIMEOUT_EN
    // 6: controller never ready -> watchdog
    hang            = 1'b1;
    bus.rq1_read_en = 1'b1;
    bus.rq1_address = 32'd1029;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rq1_done && n < 200);
    chk("t6_latency", n, 66);
    chk("t6_err", bus.arb_error, 1'b1);
    chk("t6_rd1", bus.rq1_read_data, 32'hDEAD_BEEF);
    chk("t6_re_off", bus.mem_read_en, 1'b0);
    bus.rq1_read_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_sticky", bus.arb_error, 1'b1);
    hang = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", bus.arb_error, 1'b0);
    rst = 1'b1;
    @(negedge clk);
`else
    chk("err_tied", bus.arb_error, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
